// File: rtl/spi_master_if.sv
// SPI master bundle: byte-stream handshake toward the host plus the four SPI pins.
// Ports: tx_data/tx_last/tx_valid/tx_ready, rx_data/rx_valid, busy, spi_sck/mosi/miso/cs_n.
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;

    modport master (
        input  tx_data, tx_last, tx_valid, spi_miso,
        output tx_ready, rx_data, rx_valid, busy,
        output spi_sck, spi_mosi, spi_cs_n
    );

    modport slave (
        output tx_data, tx_last, tx_valid, spi_miso,
        input  tx_ready, rx_data, rx_valid, busy,
        input  spi_sck, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: streams bytes MSB first under one chip-select burst per tx_last.
// Ports: clk_80, rst_n (sync, active low), bus (spi_master_if.master).
module spi_master #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_GAP      = 2
) (
    input  logic         clk_80,
    input  logic         rst_n,
    spi_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, NEXT, END} state_t;

    localparam logic [7:0] HP_M1  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);

    state_t     r_state;
    logic [7:0] r_div;
    logic [7:0] r_half;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_last;
    logic       r_gap;
    logic       r_sck;
    logic       r_mosi;
    logic       r_cs_n;
    logic       r_tx_ready;
    logic       r_busy;

    logic       w_accept;
    logic       w_div_done;

    assign w_accept   = bus.tx_valid && r_tx_ready;
    assign w_div_done = (r_div == HP_M1);

    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = r_busy;
    assign bus.spi_sck  = r_sck;
    assign bus.spi_mosi = r_mosi;
    assign bus.spi_cs_n = r_cs_n;

    always_ff @(posedge clk_80) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_div      <= 8'd0;
            r_half     <= 8'd0;
            r_tx       <= 8'd0;
            r_rx       <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_last     <= 1'b0;
            r_gap      <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                IDLE, NEXT: begin
                    if (w_accept) begin
                        r_state    <= SHIFT;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cs_n     <= 1'b0;
                        r_tx       <= bus.tx_data;
                        r_mosi     <= bus.tx_data[7];
                        r_last     <= bus.tx_last;
                        r_div      <= 8'd0;
                        r_half     <= 8'd0;
                    end else if (r_state == IDLE) begin
                        // ready comes up one cycle after reset release
                        r_tx_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_div_done) begin
                        r_div  <= 8'd0;
                        r_half <= r_half + 8'd1;
                        r_sck  <= ~r_sck;
                        if (!r_sck) begin
                            r_rx <= {r_rx[6:0], bus.spi_miso};
                        end else if (r_half == 8'd15) begin
                            // 8th fall: r_rx already holds all 8 bits
                            r_rx_data  <= r_rx;
                            r_rx_valid <= 1'b1;
                            if (r_last) begin
                                r_state <= END;
                                r_gap   <= 1'b0;
                            end else begin
                                r_state    <= NEXT;
                                r_tx_ready <= 1'b1;
                            end
                        end else begin
                            r_mosi <= r_tx[6];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                END: begin
                    // hold phase keeps cs low, gap phase keeps it high
                    if (!r_gap) begin
                        if (w_div_done) begin
                            r_div  <= 8'd0;
                            r_gap  <= 1'b1;
                            r_cs_n <= 1'b1;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end else if (r_div == GAP_M1) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_mosi     <= 1'b0;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 4, meaning spi_sck half-period in clk_80 cycles, legal range 1..255 (4 gives 10 MHz SCK).
REQ-002 The block SHALL have parameter CS_GAP, default 2, meaning the minimum number of clk_80 cycles spi_cs_n stays high between bursts, legal range 1..255.
REQ-003 clk_80  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 tx_data  input  8  byte to transmit, MSB first.
REQ-006 tx_last  input  1  qualifies tx_data: final byte of a chip-select burst.
REQ-007 tx_valid  input  1  tx_data/tx_last valid.
REQ-008 tx_ready  output  1  block accepts a byte this cycle.
REQ-009 rx_data  output  8  byte received on spi_miso, MSB first.
REQ-010 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 spi_sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 spi_mosi  output  1  serial data out.
REQ-014 spi_miso  input  1  serial data in, treated as synchronous to clk_80.
REQ-015 spi_cs_n  output  1  active-low chip select.

Function
REQ-016 A byte SHALL be accepted on any rising edge with tx_valid=1 and tx_ready=1; the block SHALL ignore tx_data, tx_last and tx_valid in every other cycle.
REQ-017 The FSM states SHALL be IDLE, SHIFT, NEXT and END.
REQ-018 tx_ready SHALL be 1 only in IDLE and in NEXT.
REQ-019 IDLE -> SHIFT on accept: in the following cycle spi_cs_n=0 and spi_mosi=tx_data[7].
REQ-020 In SHIFT, spi_sck SHALL toggle every HALF_PERIOD cycles, with the first rise HALF_PERIOD cycles after SHIFT entry; each byte has exactly 8 rises and 8 falls, so 16*HALF_PERIOD cycles per byte.
REQ-021 spi_miso SHALL be sampled on the clk_80 edge that drives spi_sck high.
REQ-022 spi_mosi SHALL advance to the next bit on the edge that drives spi_sck low, except after the 8th fall.
REQ-023 On the 8th fall, the block SHALL register rx_data and pulse rx_valid for exactly one cycle, in the same cycle spi_sck goes low.
REQ-024 After the 8th fall, the FSM SHALL go to END if the current byte had tx_last=1, and to NEXT otherwise.
REQ-025 In NEXT, spi_cs_n SHALL stay 0 and spi_sck 0 for an unbounded wait; on accept, the FSM SHALL go to SHIFT with spi_mosi=tx_data[7] in the next cycle, and REQ-020 timing restarts.
REQ-026 In END, spi_cs_n SHALL stay 0 for HALF_PERIOD cycles, then be 1 for CS_GAP cycles, then the FSM SHALL return to IDLE.
REQ-027 The block SHALL have no abort path; a burst ends only through tx_last.
REQ-028 With HALF_PERIOD=1, spi_sck SHALL toggle every cycle and REQ-020..REQ-026 SHALL still hold.
REQ-029 All internal counters SHALL be 8 bits wide and saturate-free; a counter SHALL wrap only when the FSM reloads it.

Reset
REQ-030 With rst_n=0 at a rising edge, the block SHALL enter IDLE with: spi_cs_n=1, spi_sck=0, spi_mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0.
REQ-031 tx_ready SHALL rise in the first cycle after rst_n returns to 1.
REQ-032 Reset asserted mid-byte or mid-burst SHALL abandon the transfer on the next edge with no rx_valid pulse and spi_cs_n forced to 1.

Verification (HALF_PERIOD=4, CS_GAP=2; cycle 0 = accept edge)
REQ-033 Single byte 0xA5 with tx_last=1 and MISO slave returning 0x3C -> spi_cs_n=0 at cycle 1, first spi_sck rise at cycle 5, MOSI bits 1010_0101, rx_valid with rx_data=0x3C at cycle 65, spi_cs_n=1 at cycle 69, tx_ready=1 at cycle 71.
REQ-034 Two-byte burst 0x01 then 0xFF(last), with tx_valid delayed 10 cycles after the first rx_valid -> spi_cs_n stays 0 throughout, spi_sck stays low during the gap, two rx_valid pulses, 16 sck rises in total.
REQ-035 Back-to-back burst with tx_valid held high -> NEXT lasts exactly one cycle and there is no spi_cs_n glitch between bytes.
REQ-036 HALF_PERIOD=1, byte 0x80 last -> spi_sck toggles every cycle, rx_valid at cycle 17.
REQ-037 rst_n pulsed low at cycle 30 of a byte -> next edge gives spi_cs_n=1, spi_sck=0, no rx_valid; the next transfer completes normally.
REQ-038 tx_valid asserted during SHIFT/END -> not accepted (tx_ready=0) and the byte is held by the source until NEXT or IDLE.
